// File: rtl/ble_command_scheduler.sv
// Shares the AT-command encoder between host TX payloads and a periodic RX poll,
// then streams each encoded command byte-by-byte to the UART transmitter.
module ble_command_scheduler #(
    parameter int POLL_PERIOD = 1000000,
    parameter int ENC_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_valid,
    input  logic [31:0]  tx_data,
    output logic         tx_ready,
    output logic         enc_start,
    output logic [3:0]   enc_command_select,
    output logic [32:0]  enc_input_data,
    input  logic [143:0] enc_output_data,
    input  logic         enc_done,
    output logic [7:0]   uart_tx_data,
    output logic         uart_tx_valid,
    input  logic         uart_tx_ready,
    output logic         busy,
    output logic         cmd_done,
    output logic         cmd_kind,
    output logic         err_timeout
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = $clog2(ENC_TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ENC_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_ENC_START     = 3'd1;
    localparam logic [2:0] S_ENC_WAIT_HIGH = 3'd2;
    localparam logic [2:0] S_SEND          = 3'd3;
    localparam logic [2:0] S_DONE          = 3'd4;

    localparam logic [3:0] SEL_TX = 4'h1;
    localparam logic [3:0] SEL_RX = 4'h2;
    localparam logic [4:0] LEN_TX = 5'd18;
    localparam logic [4:0] LEN_RX = 5'd13;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          poll_pending_q, poll_pending_d;
    logic          last_grant_q, last_grant_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [143:0]  shift_q, shift_d;
    logic [4:0]    byte_cnt_q, byte_cnt_d;
    logic          tx_ready_q, tx_ready_d;
    logic          enc_start_q, enc_start_d;
    logic [3:0]    enc_sel_q, enc_sel_d;
    logic [32:0]   enc_in_q, enc_in_d;
    logic [7:0]    uart_data_q, uart_data_d;
    logic          uart_valid_q, uart_valid_d;
    logic          busy_q, busy_d;
    logic          cmd_done_q, cmd_done_d;
    logic          cmd_kind_q, cmd_kind_d;
    logic          err_q, err_d;

    logic poll_expire;
    logic grant_tx;
    logic grant_rx;

    // tx_ready already encodes the round-robin decision, so TX wins whenever it is offered.
    assign poll_expire = (poll_cnt_q == POLL_LAST);
    assign grant_tx    = (state_q == S_IDLE) && tx_valid && tx_ready_q;
    assign grant_rx    = (state_q == S_IDLE) && !grant_tx && poll_pending_q;

    always_comb begin
        state_d      = state_q;
        poll_cnt_d   = poll_expire ? '0 : poll_cnt_q + PW'(1);
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        enc_sel_d    = enc_sel_q;
        enc_in_d     = enc_in_q;
        cmd_kind_d   = cmd_kind_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (grant_tx || grant_rx) begin
                    state_d      = S_ENC_START;
                    tmo_cnt_d    = '0;
                    last_grant_d = grant_rx;
                    cmd_kind_d   = grant_rx;
                    enc_sel_d    = grant_rx ? SEL_RX : SEL_TX;
                    if (grant_tx) begin
                        enc_in_d = {1'b0, tx_data};
                    end
                end
            end
            S_ENC_START: begin
                if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                    if (!enc_done) begin
                        state_d = S_ENC_WAIT_HIGH;
                    end
                end
            end
            S_ENC_WAIT_HIGH: begin
                // Completion on the final allowed cycle still counts as in time.
                if (enc_done) begin
                    state_d    = S_SEND;
                    shift_d    = enc_output_data;
                    byte_cnt_d = cmd_kind_q ? LEN_RX : LEN_TX;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_SEND: begin
                if (uart_valid_q && uart_tx_ready) begin
                    shift_d    = {8'h00, shift_q[143:8]};
                    byte_cnt_d = byte_cnt_q - 5'd1;
                    if (byte_cnt_q == 5'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh expiry outranks the grant that would clear the pending flag.
        poll_pending_d = poll_expire ? 1'b1 : (grant_rx ? 1'b0 : poll_pending_q);

        tx_ready_d   = (state_d == S_IDLE) && (!poll_pending_d || last_grant_d);
        enc_start_d  = (state_d == S_ENC_START);
        uart_valid_d = (state_d == S_SEND);
        uart_data_d  = shift_d[7:0];
        busy_d       = (state_d != S_IDLE);
        cmd_done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            poll_cnt_q     <= '0;
            poll_pending_q <= 1'b0;
            last_grant_q   <= 1'b1;
            tmo_cnt_q      <= '0;
            shift_q        <= '0;
            byte_cnt_q     <= '0;
            tx_ready_q     <= 1'b1;
            enc_start_q    <= 1'b0;
            enc_sel_q      <= '0;
            enc_in_q       <= '0;
            uart_data_q    <= '0;
            uart_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            cmd_done_q     <= 1'b0;
            cmd_kind_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            poll_cnt_q     <= poll_cnt_d;
            poll_pending_q <= poll_pending_d;
            last_grant_q   <= last_grant_d;
            tmo_cnt_q      <= tmo_cnt_d;
            shift_q        <= shift_d;
            byte_cnt_q     <= byte_cnt_d;
            tx_ready_q     <= tx_ready_d;
            enc_start_q    <= enc_start_d;
            enc_sel_q      <= enc_sel_d;
            enc_in_q       <= enc_in_d;
            uart_data_q    <= uart_data_d;
            uart_valid_q   <= uart_valid_d;
            busy_q         <= busy_d;
            cmd_done_q     <= cmd_done_d;
            cmd_kind_q     <= cmd_kind_d;
            err_q          <= err_d;
        end
    end

    assign tx_ready           = tx_ready_q;
    assign enc_start          = enc_start_q;
    assign enc_command_select = enc_sel_q;
    assign enc_input_data     = enc_in_q;
    assign uart_tx_data       = uart_data_q;
    assign uart_tx_valid      = uart_valid_q;
    assign busy               = busy_q;
    assign cmd_done           = cmd_done_q;
    assign cmd_kind           = cmd_kind_q;
    assign err_timeout        = err_q;

endmodule

// File: tb/tb_ble_command_scheduler.sv
// Bench for ble_command_scheduler: instance 0 never polls (TX, backpressure, timeout,
// reset), instance 1 polls every 8 cycles (RX timing and arbitration).
module tb_ble_command_scheduler;

    typedef struct {
        logic       rst;
        logic       txv;
        logic       rdy;
        logic       expTxReady;
        logic       expEncStart;
        logic       expBusy;
        logic       expUv;
        logic [7:0] expUd;
        logic       chkUd;
        logic       expDone;
    } vecT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstI       [2];
    logic         txValidI   [2];
    logic [31:0]  txDataI    [2];
    logic         uartReadyI [2];
    logic         encStuck   [2];
    logic         encDoneI   [2];
    logic [143:0] encOutI    [2];

    logic         txReady0, encStart0, uartValid0, busy0, cmdDone0, cmdKind0, err0;
    logic         txReady1, encStart1, uartValid1, busy1, cmdDone1, cmdKind1, err1;
    logic [3:0]   encSel0, encSel1;
    logic [32:0]  encIn0, encIn1;
    logic [7:0]   uartData0, uartData1;

    logic         txReadyO [2];
    logic         encStartO[2];
    logic [3:0]   encSelO  [2];
    logic [32:0]  encInO   [2];
    logic [7:0]   uartDataO[2];
    logic         uartValidO[2];
    logic         busyO    [2];
    logic         cmdDoneO [2];
    logic         cmdKindO [2];
    logic         errO     [2];

    ble_command_scheduler #(.POLL_PERIOD(1000000), .ENC_TIMEOUT(16)) dut0 (
        .clk(clk), .reset(rstI[0]), .tx_valid(txValidI[0]), .tx_data(txDataI[0]),
        .tx_ready(txReady0), .enc_start(encStart0), .enc_command_select(encSel0),
        .enc_input_data(encIn0), .enc_output_data(encOutI[0]), .enc_done(encDoneI[0]),
        .uart_tx_data(uartData0), .uart_tx_valid(uartValid0), .uart_tx_ready(uartReadyI[0]),
        .busy(busy0), .cmd_done(cmdDone0), .cmd_kind(cmdKind0), .err_timeout(err0)
    );

    ble_command_scheduler #(.POLL_PERIOD(8), .ENC_TIMEOUT(16)) dut1 (
        .clk(clk), .reset(rstI[1]), .tx_valid(txValidI[1]), .tx_data(txDataI[1]),
        .tx_ready(txReady1), .enc_start(encStart1), .enc_command_select(encSel1),
        .enc_input_data(encIn1), .enc_output_data(encOutI[1]), .enc_done(encDoneI[1]),
        .uart_tx_data(uartData1), .uart_tx_valid(uartValid1), .uart_tx_ready(uartReadyI[1]),
        .busy(busy1), .cmd_done(cmdDone1), .cmd_kind(cmdKind1), .err_timeout(err1)
    );

    always_comb begin
        txReadyO[0] = txReady0;    txReadyO[1] = txReady1;
        encStartO[0] = encStart0;  encStartO[1] = encStart1;
        encSelO[0] = encSel0;      encSelO[1] = encSel1;
        encInO[0] = encIn0;        encInO[1] = encIn1;
        uartDataO[0] = uartData0;  uartDataO[1] = uartData1;
        uartValidO[0] = uartValid0; uartValidO[1] = uartValid1;
        busyO[0] = busy0;          busyO[1] = busy1;
        cmdDoneO[0] = cmdDone0;    cmdDoneO[1] = cmdDone1;
        cmdKindO[0] = cmdKind0;    cmdKindO[1] = cmdKind1;
        errO[0] = err0;            errO[1] = err1;
    end

    function automatic logic [143:0] encodeCmd(input logic [3:0] sel, input logic [31:0] p);
        logic [143:0] r;
        string hdr;
        r = '0;
        hdr = (sel == 4'h2) ? "AT+BLEUARTRX" : "AT+BLEUARTTX=";
        for (int i = 0; i < hdr.len(); i++) r[i*8 +: 8] = hdr[i];
        if (sel == 4'h2) begin
            r[96 +: 8] = 8'h0D;
        end else begin
            r[104 +: 32] = p;
            r[136 +: 8]  = 8'h0D;
        end
        return r;
    endfunction

    // Behavioural encoder: drops done the cycle after start, raises it with data a cycle later.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rstI[g]) begin
                encDoneI[g] <= 1'b1;
                encOutI[g]  <= '0;
            end else if (encDoneI[g] && encStartO[g] && !encStuck[g]) begin
                encDoneI[g] <= 1'b0;
            end else if (!encDoneI[g]) begin
                encDoneI[g] <= 1'b1;
                encOutI[g]  <= encodeCmd(encSelO[g], encInO[g][31:0]);
            end
        end
    end

    logic [7:0] bytes0[$];
    logic [7:0] bytes1[$];
    int         kinds1[$];
    int         lens1[$];
    int         cur1 = 0;
    int         readyBusyViol = 0;

    always @(negedge clk) begin
        if (!rstI[0] && uartValidO[0] && uartReadyI[0]) bytes0.push_back(uartDataO[0]);
        if (rstI[1]) begin
            cur1 <= 0;
        end else begin
            if (uartValidO[1] && uartReadyI[1]) begin
                bytes1.push_back(uartDataO[1]);
                cur1 <= cur1 + 1;
            end
            if (cmdDoneO[1]) begin
                kinds1.push_back(int'(cmdKindO[1]));
                lens1.push_back(cur1);
                cur1 <= 0;
            end
        end
        for (int g = 0; g < 2; g++) begin
            if (busyO[g] && txReadyO[g]) readyBusyViol <= readyBusyViol + 1;
        end
    end

    int  checks = 0;
    int  errors = 0;
    vecT vecs[$];

    task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic rst, input logic txv, input logic rdy);
        rstI[inst]       = rst;
        txValidI[inst]   = txv;
        uartReadyI[inst] = rdy;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic rst, input logic txv, input logic rdy, input logic txr,
                          input logic es, input logic bsy, input logic uv, input logic [7:0] ud,
                          input logic chk, input logic dn);
        vecT v;
        v.rst = rst; v.txv = txv; v.rdy = rdy; v.expTxReady = txr; v.expEncStart = es;
        v.expBusy = bsy; v.expUv = uv; v.expUd = ud; v.chkUd = chk; v.expDone = dn;
        vecs.push_back(v);
    endtask

    function automatic logic [143:0] packStr(input string s);
        logic [143:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [143:0] packQ0(input int base, input int n);
        logic [143:0] r;
        r = '0;
        for (int i = 0; i < n; i++) if (base + i < bytes0.size()) r[i*8 +: 8] = bytes0[base + i];
        return r;
    endfunction

    initial begin
        string expTx;
        string expTx2;
        string expRx;
        int    idx;
        int    base;
        int    esCycles;
        int    edgeNum;
        int    kbase;
        int    budget;
        logic  r;
        logic [7:0]   mask;
        logic [14:0]  act;
        logic [14:0]  exp;
        logic [143:0] got;

        expTx  = "AT+BLEUARTTX=ABCD\r";
        expTx2 = "AT+BLEUARTTX=1234\r";
        expRx  = "AT+BLEUARTRX\r";

        for (int g = 0; g < 2; g++) begin
            rstI[g] = 1'b1; txValidI[g] = 1'b0; uartReadyI[g] = 1'b1;
            txDataI[g] = 32'h44434241; encStuck[g] = 1'b0;
        end

        // Single TX command on instance 0 with a 1,0,0,1 ready pattern at the start of SEND.
        addVec(1, 0, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        addVec(0, 1, 1, 0, 1, 1, 0, 8'h00, 0, 0);
        addVec(0, 0, 1, 0, 1, 1, 0, 8'h00, 0, 0);
        addVec(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0);
        addVec(0, 0, 1, 0, 0, 1, 1, expTx[0], 1, 0);
        idx = 0;
        for (int row = 5; row <= 23; row++) begin
            r = (row == 6 || row == 7) ? 1'b0 : 1'b1;
            if (r) idx++;
            addVec(0, 0, r, 0, 0, 1, 1, expTx[idx], 1, 0);
        end
        addVec(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 1);
        addVec(0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].rst, vecs[i].txv, vecs[i].rdy);
            stepCycle();
            mask = vecs[i].chkUd ? 8'hFF : 8'h00;
            act = {txReadyO[0], encStartO[0], busyO[0], uartValidO[0], cmdDoneO[0],
                   cmdKindO[0], errO[0], uartDataO[0] & mask};
            exp = {vecs[i].expTxReady, vecs[i].expEncStart, vecs[i].expBusy, vecs[i].expUv,
                   vecs[i].expDone, 1'b0, 1'b0, vecs[i].expUd & mask};
            checkOutput($sformatf("vec%0d", i), 144'(act), 144'(exp));
        end
        checkOutput("tx_handshakes", 144'(bytes0.size()), 144'(18));
        checkOutput("tx_bytes", packQ0(0, 18), packStr(expTx));

        // Encoder never drops done: command must time out after 16 cycles of enc_start.
        encStuck[0] = 1'b1;
        base = bytes0.size();
        applyStimulus(0, 0, 1, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 1);
        esCycles = 0;
        while (encStartO[0] && esCycles < 40) begin
            esCycles++;
            stepCycle();
        end
        checkOutput("timeout_cycles", 144'(esCycles), 144'(16));
        checkOutput("timeout_state", 144'({errO[0], busyO[0], txReadyO[0]}), 144'(3'b101));
        checkOutput("timeout_no_uart", 144'(bytes0.size() - base), 144'(0));
        stepCycle();
        checkOutput("err_sticky", 144'(errO[0]), 144'(1));

        // Reset clears the error; then reset in the middle of SEND after five bytes.
        encStuck[0] = 1'b0;
        txDataI[0] = 32'h34333231;
        applyStimulus(0, 1, 0, 1);
        stepCycle();
        checkOutput("reset_state", 144'({errO[0], busyO[0], txReadyO[0]}), 144'(3'b001));
        applyStimulus(0, 0, 1, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 1);
        base = bytes0.size();
        budget = 0;
        while (bytes0.size() - base < 5 && budget < 40) begin
            budget++;
            stepCycle();
        end
        applyStimulus(0, 1, 0, 0);
        stepCycle();
        checkOutput("mid_reset_outputs", 144'({uartValidO[0], busyO[0]}), 144'(2'b00));
        checkOutput("mid_reset_partial", 144'(bytes0.size() - base), 144'(5));
        applyStimulus(0, 0, 1, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 1);
        base = bytes0.size();
        budget = 0;
        while (!cmdDoneO[0] && budget < 60) begin
            budget++;
            stepCycle();
        end
        checkOutput("resend_done", 144'(cmdDoneO[0]), 144'(1));
        checkOutput("resend_count", 144'(bytes0.size() - base), 144'(18));
        checkOutput("resend_bytes", packQ0(base, 18), packStr(expTx2));

        // Instance 1: RX poll timing from reset release with no TX traffic.
        applyStimulus(1, 0, 0, 1);
        edgeNum = 0;
        do begin
            stepCycle();
            edgeNum++;
        end while (!encStartO[1] && edgeNum < 40);
        checkOutput("rx_first_start_edge", 144'(edgeNum), 144'(9));
        checkOutput("rx_select", 144'(encSelO[1]), 144'(4'h2));
        while (encStartO[1] && edgeNum < 80) begin stepCycle(); edgeNum++; end
        while (!encStartO[1] && edgeNum < 80) begin stepCycle(); edgeNum++; end
        checkOutput("rx_second_start_edge", 144'(edgeNum), 144'(27));
        checkOutput("rx_kind_len", 144'({(kinds1.size() > 0) ? kinds1[0] : -1,
                                         (lens1.size() > 0) ? lens1[0] : -1}),
                    144'({32'd1, 32'd13}));
        got = '0;
        for (int i = 0; i < 13; i++) if (i < bytes1.size()) got[i*8 +: 8] = bytes1[i];
        checkOutput("rx_bytes", got, packStr(expRx));

        // Collision of TX and a pending poll out of reset, then TX held to force alternation.
        applyStimulus(1, 1, 0, 1);
        stepCycle();
        applyStimulus(1, 0, 0, 1);
        kbase = kinds1.size();
        edgeNum = 0;
        while (edgeNum < 8) begin stepCycle(); edgeNum++; end
        txDataI[1] = 32'h44434241;
        applyStimulus(1, 0, 1, 1);
        stepCycle();
        checkOutput("collide_first_tx", 144'({encStartO[1], encSelO[1]}), 144'(5'b1_0001));
        budget = 0;
        while (kinds1.size() - kbase < 4 && budget < 300) begin
            budget++;
            stepCycle();
        end
        applyStimulus(1, 0, 0, 1);
        got = '0;
        for (int i = 0; i < 4; i++) begin
            if (kbase + i < kinds1.size()) begin
                got[i*4 +: 4]      = 4'(kinds1[kbase + i]);
                got[16 + i*8 +: 8] = 8'(lens1[kbase + i]);
            end else begin
                got[i*4 +: 4] = 4'hF;
            end
        end
        checkOutput("arb_order_len", got, 144'({8'd13, 8'd18, 8'd13, 8'd18, 4'd1, 4'd0, 4'd1, 4'd0}));
        checkOutput("ready_while_busy", 144'(readyBusyViol), 144'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
